alu_op_sequencer: RTL and testbench

// - Sequences the 16-bit ALU datapath: ADD, SUB, AND, SLL, ADDI, LW.
// - Accepts one operation at a time over a valid/ready request channel, executes it, and returns the result over a valid/ready result channel.
// - For LW, computes the effective address, runs a memory read handshake and returns the read data.
// - Sits between instruction decode (upstream) and register writeback / data memory (downstream).

---
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Request/result sequencer for the 16-bit ALU (ADD, SUB, AND,
//               SLL, ADDI, LW). Define ALU_SERIAL_SHIFT_EN for a bit-serial SLL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int W     = 16,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [IMM_W-1:0] req_imm,
    output logic             mem_req,
    output logic [W-1:0]     mem_addr,
    input  logic             mem_ack,
    input  logic [W-1:0]     mem_rdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             err_badop,
    output logic             busy
);

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_AND  = 3'd2;
    localparam logic [2:0] c_OP_SLL  = 3'd3;
    localparam logic [2:0] c_OP_ADDI = 3'd4;
    localparam logic [2:0] c_OP_LW   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEM   = 2'd1,
`ifdef ALU_SERIAL_SHIFT_EN
        S_SHIFT = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_res_data;
    logic [W-1:0] w_res_nxt;
    logic         r_err_badop;
    logic         w_err_nxt;
    logic         r_mem_req;
    logic         w_mem_req_nxt;
    logic [W-1:0] r_mem_addr;
    logic [W-1:0] w_mem_addr_nxt;

    logic [W-1:0] w_imm_sext;
    logic [7:0]   w_amt;
    logic         w_amt_big;
    logic [4:0]   w_amt_clamp;
    logic [W-1:0] w_sll;

    assign w_imm_sext  = {{(W-IMM_W){req_imm[IMM_W-1]}}, req_imm};
    assign w_amt       = req_b[7:0];
    assign w_amt_big   = (w_amt >= 8'd16);
    assign w_amt_clamp = w_amt_big ? 5'd16 : w_amt[4:0];
    assign w_sll       = w_amt_big ? '0 : (req_a << w_amt[3:0]);

`ifdef ALU_SERIAL_SHIFT_EN
    logic [4:0] r_shift_cnt;
    logic [4:0] w_shift_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_res_nxt      = r_res_data;
        w_err_nxt      = r_err_badop;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
`ifdef ALU_SERIAL_SHIFT_EN
        w_shift_cnt_nxt = r_shift_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                    case (req_op)
                        c_OP_ADD:  w_res_nxt = req_a + req_b;
                        c_OP_SUB:  w_res_nxt = req_a - req_b;
                        c_OP_AND:  w_res_nxt = req_a & req_b;
                        c_OP_ADDI: w_res_nxt = req_a + w_imm_sext;
                        c_OP_SLL: begin
`ifdef ALU_SERIAL_SHIFT_EN
                            if (w_amt_clamp != 5'd0) begin
                                w_res_nxt       = req_a;
                                w_shift_cnt_nxt = w_amt_clamp;
                                w_state_nxt     = S_SHIFT;
                            end else begin
                                w_res_nxt = w_sll;
                            end
`else
                            w_res_nxt = w_sll;
`endif
                        end
                        c_OP_LW: begin
                            w_mem_addr_nxt = req_a + w_imm_sext;
                            w_mem_req_nxt  = 1'b1;
                            w_state_nxt    = S_MEM;
                        end
                        default: begin
                            w_res_nxt = '0;
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    w_res_nxt     = mem_rdata;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_DONE;
                end
            end
`ifdef ALU_SERIAL_SHIFT_EN
            S_SHIFT: begin
                // Final shift lands on the edge the counter hits zero.
                w_res_nxt       = {r_res_data[W-2:0], 1'b0};
                w_shift_cnt_nxt = r_shift_cnt - 5'd1;
                if (r_shift_cnt == 5'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (res_ready) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_res_data  <= '0;
            r_err_badop <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
            r_shift_cnt <= 5'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_res_data  <= w_res_nxt;
            r_err_badop <= w_err_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
`ifdef ALU_SERIAL_SHIFT_EN
            r_shift_cnt <= w_shift_cnt_nxt;
`endif
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign res_data  = r_res_data;
    assign err_badop = r_err_badop;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench for alu_op_sequencer (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_imm;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        err_badop;
    logic        busy;

    int n_cmp;
    int n_bad;

    alu_op_sequencer #(.W(16), .IMM_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_imm   (req_imm),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err_badop (err_badop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns at the negedge one cycle after accept.
    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] imm);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_imm   = imm;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 16'h5A5A;
        req_b     = 16'hA5A5;
        req_imm   = 8'h33;
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || err_badop !== 1'b0) begin
            n_bad++;
            $display("FAIL take: valid=%b ready=%b err=%b expected 0/1/0",
                     res_valid, req_ready, err_badop);
        end
    endtask

    task automatic check_alu(input string name, input logic [2:0] op,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [7:0] imm, input logic [15:0] exp);
        issue(op, a, b, imm);
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== exp || err_badop !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: valid=%b data=%h err=%b expected 1/%h/0",
                     name, res_valid, res_data, err_badop, exp);
        end
        take_result();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 16'h0 ||
            res_valid !== 1'b0 || res_data !== 16'h0 || err_badop !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b mreq=%b addr=%h val=%b data=%h err=%b busy=%b expected 1/0/0000/0/0000/0/0",
                     req_ready, mem_req, mem_addr, res_valid, res_data, err_badop, busy);
        end
    endtask

    task automatic test_arith();
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_accept_valid: got %b expected 0", res_valid);
        end
        check_alu("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000);
        check_alu("sub_borrow", 3'd1, 16'h0000, 16'h0001, 8'h00, 16'hFFFF);
        check_alu("addi_neg", 3'd4, 16'h0010, 16'h0000, 8'hF0, 16'h0000);
        check_alu("addi_pos", 3'd4, 16'h1234, 16'hFFFF, 8'h7F, 16'h12B3);
        check_alu("and", 3'd2, 16'hF0F0, 16'h3C3C, 8'h00, 16'h3030);
    endtask

    task automatic test_sll();
        check_alu("sll_15", 3'd3, 16'h0001, 16'h000F, 8'h00, 16'h8000);
        check_alu("sll_16", 3'd3, 16'h0001, 16'h0010, 8'h00, 16'h0000);
        check_alu("sll_ff", 3'd3, 16'h0001, 16'h00FF, 8'h00, 16'h0000);
        check_alu("sll_hi_ignored", 3'd3, 16'h0001, 16'h0103, 8'h00, 16'h0008);
        check_alu("sll_0", 3'd3, 16'hABCD, 16'h0000, 8'h00, 16'hABCD);
    endtask

    task automatic test_lw();
        issue(3'd5, 16'h1000, 16'h0000, 8'h80);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0F80 || res_valid !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL lw_wait[%0d]: mreq=%b addr=%h val=%b busy=%b expected 1/0f80/0/1",
                         i, mem_req, mem_addr, res_valid, busy);
            end
            if (i < 2) @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 16'hBEEF || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_result: val=%b data=%h mreq=%b expected 1/beef/0",
                     res_valid, res_data, mem_req);
        end
        take_result();
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        @(negedge clk);
        mem_ack   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || res_data !== 16'hBEEF || mem_req !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_ack: val=%b data=%h mreq=%b busy=%b rdy=%b expected 0/beef/0/0/1",
                     res_valid, res_data, mem_req, busy, req_ready);
        end
    endtask

    task automatic test_backpressure();
        issue(3'd7, 16'h1111, 16'h2222, 8'h00);
        req_valid = 1'b1;
        req_op    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 16'h0000 || err_badop !== 1'b1 || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: val=%b data=%h err=%b rdy=%b expected 1/0000/1/0",
                         i, res_valid, res_data, err_badop, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        take_result();
    endtask

    task automatic test_reset_in_mem();
        issue(3'd5, 16'h2000, 16'h0000, 8'h04);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h2004) begin
            n_bad++;
            $display("FAIL rst_mem_pre: mreq=%b addr=%h expected 1/2004", mem_req, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mem: mreq=%b val=%b rdy=%b busy=%b expected 0/0/1/0",
                     mem_req, res_valid, req_ready, busy);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ack: val=%b data=%h busy=%b expected 0/0000/0",
                     res_valid, res_data, busy);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h0001;
        req_b     = 16'h0002;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 16'h0003) begin
            n_bad++;
            $display("FAIL b2b_first: val=%b data=%h expected 1/0003", res_valid, res_data);
        end
        req_op    = 3'd1;
        req_a     = 16'h0005;
        req_b     = 16'h0003;
        res_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap: val=%b rdy=%b expected 0/1", res_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 16'h0002) begin
            n_bad++;
            $display("FAIL b2b_second: val=%b data=%h expected 1/0002", res_valid, res_data);
        end
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: val=%b busy=%b expected 0/0", res_valid, busy);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_imm   = 8'h0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        res_ready = 1'b0;
        test_reset();
        test_arith();
        test_sll();
        test_lw();
        test_stray_ack();
        test_backpressure();
        test_reset_in_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
